cache_fill_ctrl: RTL and testbench

CACHE_FILL_CTRL -- requirements
Module: cache_fill_ctrl

---
 rtl/cache_fill_ctrl_pkg.sv | 22 ++
 rtl/cache_fill_ctrl_fill_counter.sv | 25 ++
 rtl/cache_fill_ctrl.sv | 124 ++++++++++++
 tb/tb_cache_fill_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_fill_ctrl_pkg.sv
// Shared types and field constants for the cache line fill controller.
package cache_fill_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_TAG
    } state_e;

    localparam int unsigned LINE_WORDS = 8;
    localparam int unsigned CNT_W      = 3;

    // Byte-address fields of a 16-byte line in a 16-bit address space
    localparam int unsigned SET_MSB = 10;
    localparam int unsigned SET_LSB = 4;
    localparam int unsigned TAG_MSB = 15;
    localparam int unsigned TAG_LSB = 11;

    localparam logic FILL_SEL_I = 1'b0;
    localparam logic FILL_SEL_D = 1'b1;

endpackage

// File: rtl/cache_fill_ctrl_fill_counter.sv
// Word counter for one line: 3-bit count with clear priority over enable.
module fill_counter
    import cache_fill_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             last
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 3'd1;
        end
    end

    assign last = (count == 3'(LINE_WORDS - 1));

endmodule

// File: rtl/cache_fill_ctrl.sv
// Line fill controller shared by the I- and D-cache: arbitrates misses,
// streams eight words from memory into the data array, then writes the tag.
module cache_fill_ctrl
    import cache_fill_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned WORDS  = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_miss,
    input  logic [ADDR_W-1:0]            i_miss_addr,
    input  logic                         d_miss,
    input  logic [ADDR_W-1:0]            d_miss_addr,
    output logic                         mem_en,
    output logic [ADDR_W-1:0]            mem_addr,
    input  logic                         mem_valid,
    input  logic [15:0]                  mem_data,
    output logic [SET_MSB-SET_LSB:0]     fill_set,
    output logic [CNT_W-1:0]             fill_word,
    output logic [15:0]                  fill_data,
    output logic                         data_we,
    output logic                         tag_we,
    output logic [TAG_MSB-TAG_LSB:0]     fill_tag,
    output logic                         fill_sel,
    output logic                         i_done,
    output logic                         d_done,
    output logic                         busy
);

    state_e             state;
    logic [ADDR_W-1:0]  addr_q;
    logic               grant;
    logic               issue_en;
    logic               recv_en;
    logic               recv_done;
    logic               issue_last;
    logic               recv_last;
    logic [CNT_W-1:0]   issue_cnt;
    logic [CNT_W-1:0]   recv_cnt;
    logic               unused_addr_bits;

    assign grant     = (state == ST_IDLE) && (i_miss || d_miss);
    assign issue_en  = (state == ST_FILL) && mem_en;
    assign recv_en   = (state == ST_FILL) && mem_valid;
    assign recv_done = recv_en && recv_last && (WORDS == LINE_WORDS);

    fill_counter u_issue_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (issue_en),
        .clr   (grant),
        .count (issue_cnt),
        .last  (issue_last)
    );

    fill_counter u_recv_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (recv_en),
        .clr   (grant),
        .count (recv_cnt),
        .last  (recv_last)
    );

    // Issue count 8 is represented by mem_en low with the counter wrapped to 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            addr_q   <= '0;
            fill_sel <= FILL_SEL_I;
            mem_en   <= 1'b0;
            tag_we   <= 1'b0;
            i_done   <= 1'b0;
            d_done   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant) begin
                        state    <= ST_FILL;
                        busy     <= 1'b1;
                        mem_en   <= 1'b1;
                        fill_sel <= d_miss ? FILL_SEL_D : FILL_SEL_I;
                        addr_q   <= d_miss ? d_miss_addr : i_miss_addr;
                    end
                end
                ST_FILL: begin
                    if (issue_en && issue_last) begin
                        mem_en <= 1'b0;
                    end
                    if (recv_done) begin
                        state  <= ST_TAG;
                        tag_we <= 1'b1;
                        if (fill_sel == FILL_SEL_D) begin
                            d_done <= 1'b1;
                        end else begin
                            i_done <= 1'b1;
                        end
                    end
                end
                ST_TAG: begin
                    state  <= ST_IDLE;
                    tag_we <= 1'b0;
                    i_done <= 1'b0;
                    d_done <= 1'b0;
                    busy   <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_addr         = {addr_q[ADDR_W-1:4], issue_cnt, 1'b0};
    assign fill_set         = addr_q[SET_MSB:SET_LSB];
    assign fill_tag         = addr_q[TAG_MSB:TAG_LSB];
    assign fill_word        = recv_cnt;
    assign fill_data        = mem_data;
    assign data_we          = recv_en;
    assign unused_addr_bits = ^addr_q[3:0];

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Scenario table plus hand sequences, checked by address/write/tag scoreboards.
module tb_cache_fill_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_miss, d_miss;
    logic [15:0] i_miss_addr, d_miss_addr;
    logic        mem_en;
    logic [15:0] mem_addr;
    logic        mem_valid;
    logic [15:0] mem_data;
    logic [6:0]  fill_set;
    logic [2:0]  fill_word;
    logic [15:0] fill_data;
    logic        data_we, tag_we;
    logic [4:0]  fill_tag;
    logic        fill_sel, i_done, d_done, busy;

    cache_fill_ctrl #(.ADDR_W(16), .WORDS(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_miss(i_miss), .i_miss_addr(i_miss_addr),
        .d_miss(d_miss), .d_miss_addr(d_miss_addr),
        .mem_en(mem_en), .mem_addr(mem_addr),
        .mem_valid(mem_valid), .mem_data(mem_data),
        .fill_set(fill_set), .fill_word(fill_word), .fill_data(fill_data),
        .data_we(data_we), .tag_we(tag_we), .fill_tag(fill_tag),
        .fill_sel(fill_sel), .i_done(i_done), .d_done(d_done), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sel;
        logic [6:0]  set;
        logic [2:0]  word;
        logic [15:0] data;
    } wr_t;
    typedef struct {
        logic       sel;
        logic [4:0] tag;
    } tag_t;
    typedef struct {
        int          due;
        logic [15:0] addr;
    } pend_t;
    typedef struct {
        logic        im;
        logic [15:0] ia;
        logic        dm;
        logic [15:0] da;
        int          lat;
        int          drop;
        int          d_exp;
        int          i_exp;
    } scn_t;

    logic [15:0] exp_addr[$];
    wr_t         exp_wr[$];
    tag_t        exp_tag[$];
    pend_t       pend[$];

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   lat      = 1;
    int   wr_seen  = 0;
    logic spur     = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] mdata(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'hC35A;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic push_fill(input logic sel, input logic [15:0] addr);
        logic [15:0] a;
        for (int unsigned w = 0; w < 8; w++) begin
            a = {addr[15:4], 3'(w), 1'b0};
            exp_addr.push_back(a);
            exp_wr.push_back('{sel, addr[10:4], 3'(w), mdata(a)});
        end
        exp_tag.push_back('{sel, addr[15:11]});
    endtask

    // Memory: a request seen in cycle k returns data in cycle k+lat
    initial begin
        pend_t p;
        mem_valid = 1'b0;
        mem_data  = '0;
        forever begin
            @(posedge clk); #1;
            mem_valid = spur;
            mem_data  = spur ? 16'h7777 : 16'h0000;
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                p = pend.pop_front();
                mem_valid = 1'b1;
                mem_data  = mdata(p.addr);
            end
            if (mem_en) begin
                if (exp_addr.size() == 0) chk("mem_en_extra", {31'b0, mem_en}, 32'd0);
                else chk("mem_addr", {16'b0, mem_addr}, {16'b0, exp_addr.pop_front()});
                pend.push_back('{cyc + lat, mem_addr});
            end
        end
    end

    initial begin
        wr_t  e;
        tag_t t;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (data_we) begin
                    wr_seen++;
                    if (exp_wr.size() == 0) chk("data_we_extra", {31'b0, data_we}, 32'd0);
                    else begin
                        e = exp_wr.pop_front();
                        chk("fill_word", {29'b0, fill_word}, {29'b0, e.word});
                        chk("fill_set", {25'b0, fill_set}, {25'b0, e.set});
                        chk("fill_data", {16'b0, fill_data}, {16'b0, e.data});
                        chk("fill_sel_wr", {31'b0, fill_sel}, {31'b0, e.sel});
                    end
                end
                if (tag_we) begin
                    if (exp_tag.size() == 0) chk("tag_we_extra", {31'b0, tag_we}, 32'd0);
                    else begin
                        t = exp_tag.pop_front();
                        chk("fill_tag", {27'b0, fill_tag}, {27'b0, t.tag});
                        chk("fill_sel_tag", {31'b0, fill_sel}, {31'b0, t.sel});
                        chk("done_pair", {30'b0, d_done, i_done}, {30'b0, t.sel, ~t.sel});
                    end
                end else if (i_done || d_done) begin
                    chk("done_without_tag", {30'b0, d_done, i_done}, 32'd0);
                end
            end
        end
    end

    task automatic run_scn(input scn_t s);
        int start, el, d_at, i_at;
        lat = s.lat;
        if (s.dm) push_fill(1'b1, s.da);
        if (s.im) push_fill(1'b0, s.ia);
        i_miss = s.im; i_miss_addr = s.ia;
        d_miss = s.dm; d_miss_addr = s.da;
        start = cyc;
        d_at = -1; i_at = -1;
        for (int n = 0; n < 80; n++) begin
            @(posedge clk); #1;
            el = cyc - start;
            if (el == 1) chk("busy_after_grant", {31'b0, busy}, 32'd1);
            if (s.drop != 0 && el == s.drop) d_miss = 1'b0;
            if (d_done && d_at < 0) begin d_at = el; d_miss = 1'b0; end
            if (i_done && i_at < 0) begin i_at = el; i_miss = 1'b0; end
            if ((!s.dm || d_at >= 0) && (!s.im || i_at >= 0)) break;
        end
        i_miss = 1'b0; d_miss = 1'b0;
        if (s.dm) chk("d_done_cycle", d_at, s.d_exp);
        if (s.im) chk("i_done_cycle", i_at, s.i_exp);
        @(posedge clk); #1;
        chk("busy_after_done", {31'b0, busy}, 32'd0);
        repeat (lat + 1) @(posedge clk);
        #1;
        chk("queues_drained", exp_addr.size() + exp_wr.size() + exp_tag.size(), 0);
    endtask

    scn_t tbl[7];
    scn_t rs;
    int   base;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        //          im    ia        dm    da        lat drop d_exp i_exp
        tbl[0] = '{1'b0, 16'h0000, 1'b1, 16'h1234, 1, 0, 10, 0};
        tbl[1] = '{1'b1, 16'h0800, 1'b0, 16'h0000, 1, 0, 0,  10};
        tbl[2] = '{1'b1, 16'h0800, 1'b1, 16'h0040, 1, 0, 10, 21};
        tbl[3] = '{1'b0, 16'h0000, 1'b1, 16'hFFFE, 4, 0, 13, 0};
        tbl[4] = '{1'b1, 16'h7AB0, 1'b0, 16'h0000, 2, 0, 0,  11};
        tbl[5] = '{1'b1, 16'h3FF0, 1'b1, 16'hC00E, 3, 0, 12, 25};
        tbl[6] = '{1'b0, 16'h0000, 1'b1, 16'h2468, 1, 3, 10, 0};

        rst_n = 1'b0;
        i_miss = 1'b0; d_miss = 1'b0;
        i_miss_addr = '0; d_miss_addr = '0;
        #3;
        chk("rst_mem_en", {31'b0, mem_en}, 32'd0);
        chk("rst_mem_addr", {16'b0, mem_addr}, 32'd0);
        chk("rst_data_we", {31'b0, data_we}, 32'd0);
        chk("rst_tag_we", {31'b0, tag_we}, 32'd0);
        chk("rst_dones", {30'b0, i_done, d_done}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_fill_sel", {31'b0, fill_sel}, 32'd0);
        chk("rst_fill_word", {29'b0, fill_word}, 32'd0);
        chk("rst_fill_set", {25'b0, fill_set}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (tbl[k]) run_scn(tbl[k]);

        // Stray data while idle must be ignored
        spur = 1'b1;
        repeat (3) begin
            @(posedge clk); #2;
            chk("spur_data_we", {31'b0, data_we}, 32'd0);
            chk("spur_busy", {31'b0, busy}, 32'd0);
        end
        spur = 1'b0;
        @(posedge clk); #1;

        // Reset after three words: fill abandoned, stale returns ignored
        lat = 2;
        push_fill(1'b1, 16'h5670);
        d_miss = 1'b1; d_miss_addr = 16'h5670;
        base = wr_seen;
        for (int n = 0; n < 40 && wr_seen < base + 3; n++) begin
            @(posedge clk); #1;
        end
        chk("words_before_reset", wr_seen - base, 3);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_mem_en", {31'b0, mem_en}, 32'd0);
        chk("midrst_tag_we", {31'b0, tag_we}, 32'd0);
        d_miss = 1'b0;
        exp_addr.delete(); exp_wr.delete(); exp_tag.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int n = 0; n < 20 && pend.size() > 0; n++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        chk("post_rst_busy", {31'b0, busy}, 32'd0);
        chk("post_rst_pend", pend.size(), 0);

        rs = '{1'b0, 16'h0000, 1'b1, 16'h5670, 1, 0, 10, 0};
        run_scn(rs);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
